hex_counter_display: RTL and testbench

Parametrised multi-digit up/down counter with a built-in seven-segment driver. It replaces hand-wired single-digit hex decoders in the board top level.
- Counts in hexadecimal or BCD at a prescaled tick rate, supports parallel load and optional leading-zero blanking.
- Drives DIGITS active-low seven-segment outputs, one per board HEX display.
- Sits directly under the board top level; fed by CLOCK_50, KEY and SW.

---
 rtl/hex_counter_display.sv | 146 ++++++++++++++
 tb/tb_hex_counter_display.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hex_counter_display.sv
// Multi-digit hex/BCD up/down counter with prescaled tick, parallel load and
// registered active-low seven-segment outputs with optional leading-zero blanking.
module hex_counter_display #(
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  mode_bcd,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    localparam logic [6:0] SegZero = 7'b1000000;
    localparam logic [6:0] SegBlank = 7'b1111111;

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [4*DIGITS-1:0]   value_q, value_d, cnt_next;
    logic                  wrap_q, wrap_d;
    logic [7*DIGITS-1:0]   seg_q, seg_d;
    logic                  tick;
    logic                  cy, cy_out, zero_above;
    logic [3:0]            maxd, d, nd;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick = en && (pcnt_q == PMAX);

    always_comb begin
        pcnt_d = pcnt_q;
        if (load) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end
    end

    // Ripple carry/borrow through the digits; an illegal BCD digit on the way
    // down saturates to MAX and absorbs the borrow.
    always_comb begin
        maxd     = mode_bcd ? 4'd9 : 4'd15;
        cy       = 1'b1;
        cnt_next = value_q;
        d        = '0;
        nd       = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d  = value_q[4*i +: 4];
            nd = d;
            if (cy) begin
                if (up) begin
                    if (d >= maxd) begin
                        nd = 4'd0;
                    end else begin
                        nd = d + 4'd1;
                        cy = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        nd = maxd;
                    end else if (d > maxd) begin
                        nd = maxd;
                        cy = 1'b0;
                    end else begin
                        nd = d - 4'd1;
                        cy = 1'b0;
                    end
                end
            end
            cnt_next[4*i +: 4] = nd;
        end
        cy_out = cy;
    end

    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        if (load) begin
            value_d = load_val;
        end else if (tick) begin
            value_d = cnt_next;
            wrap_d  = cy_out;
        end
    end

    // Scan from the top digit so zero_above covers this digit and all above it.
    always_comb begin
        zero_above = 1'b1;
        seg_d      = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above && (value_q[4*i +: 4] == 4'd0);
            seg_d[7*i +: 7] = (blank_lz && zero_above && (i > 0)) ? SegBlank
                                                                  : decode(value_q[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q  <= '0;
            value_q <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= {DIGITS{SegZero}};
        end else begin
            pcnt_q  <= pcnt_d;
            value_q <= value_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
        end
    end

    assign value = value_q;
    assign wrap  = wrap_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_hex_counter_display.sv
// Directed bench for hex_counter_display: 2 digits, DIV=10, table of
// load-then-tick vectors plus hand sequences for enable stretch and async reset.
module tb_hex_counter_display;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned DIV    = 10;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        up;
    logic        mode_bcd;
    logic        load;
    logic [7:0]  load_val;
    logic        blank_lz;
    logic [7:0]  value;
    logic        wrap;
    logic [13:0] seg;

    int checks;
    int failures;

    typedef struct {
        logic [7:0]  lv;
        logic        up;
        logic        bcd;
        logic [7:0]  ev;
        logic        ew;
        logic [13:0] es;
    } vec_t;

    vec_t vecs[12];

    hex_counter_display #(
        .DIGITS  (DIGITS),
        .CLK_HZ  (10),
        .TICK_HZ (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .mode_bcd (mode_bcd),
        .load     (load),
        .load_val (load_val),
        .blank_lz (blank_lz),
        .value    (value),
        .wrap     (wrap),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 14'b1000000_1000000};
        vecs[1]  = '{8'h99, 1'b1, 1'b1, 8'h00, 1'b1, 14'b1000000_1000000};
        vecs[2]  = '{8'h00, 1'b0, 1'b1, 8'h99, 1'b1, 14'b0010000_0010000};
        vecs[3]  = '{8'h1A, 1'b1, 1'b1, 8'h20, 1'b0, 14'b0100100_1000000};
        vecs[4]  = '{8'h1A, 1'b0, 1'b1, 8'h19, 1'b0, 14'b1111001_0010000};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 14'b0001110_0001110};
        vecs[6]  = '{8'h0F, 1'b1, 1'b0, 8'h10, 1'b0, 14'b1111001_1000000};
        vecs[7]  = '{8'h30, 1'b0, 1'b1, 8'h29, 1'b0, 14'b0100100_0010000};
        vecs[8]  = '{8'h29, 1'b1, 1'b1, 8'h30, 1'b0, 14'b0110000_1000000};
        vecs[9]  = '{8'hB5, 1'b1, 1'b1, 8'hB6, 1'b0, 14'b0000011_0000010};
        vecs[10] = '{8'hC0, 1'b0, 1'b1, 8'h99, 1'b0, 14'b0010000_0010000};
        vecs[11] = '{8'hF9, 1'b1, 1'b1, 8'h00, 1'b1, 14'b1000000_1000000};

        rst_n    = 1'b1;
        en       = 1'b0;
        up       = 1'b1;
        mode_bcd = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        blank_lz = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check("reset value", 16'(value), 16'h0000);
        check("reset wrap", 16'(wrap), 16'h0000);
        check("reset seg", 16'(seg), 16'(14'b1000000_1000000));

        blank_lz = 1'b0;
        en       = 1'b1;
        #6 rst_n = 1'b1;

        steps(9);
        check("startup before tick", 16'(value), 16'h0000);
        step();
        check("startup first tick", 16'(value), 16'h0001);
        check("startup wrap", 16'(wrap), 16'h0000);
        check("seg lags value", 16'(seg[6:0]), 16'(7'b1000000));
        step();
        check("seg digit0 one", 16'(seg[6:0]), 16'(7'b1111001));
        check("seg digit1 zero", 16'(seg[13:7]), 16'(7'b1000000));
        blank_lz = 1'b1;
        step();
        check("seg digit1 blanked", 16'(seg[13:7]), 16'(7'b1111111));
        check("seg digit0 kept", 16'(seg[6:0]), 16'(7'b1111001));
        blank_lz = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            load     = 1'b1;
            load_val = vecs[i].lv;
            up       = vecs[i].up;
            mode_bcd = vecs[i].bcd;
            step();
            load = 1'b0;
            steps(DIV - 1);
            check($sformatf("vec%0d loaded", i), 16'(value), 16'(vecs[i].lv));
            check($sformatf("vec%0d no early wrap", i), 16'(wrap), 16'h0000);
            step();
            check($sformatf("vec%0d value", i), 16'(value), 16'(vecs[i].ev));
            check($sformatf("vec%0d wrap", i), 16'(wrap), 16'(vecs[i].ew));
            step();
            check($sformatf("vec%0d wrap one cycle", i), 16'(wrap), 16'h0000);
            check($sformatf("vec%0d seg", i), 16'(seg), 16'(vecs[i].es));
        end

        // Enable stretch: 5 disabled cycles push the tick to 15 cycles after the load.
        load     = 1'b1;
        load_val = 8'h00;
        up       = 1'b1;
        mode_bcd = 1'b0;
        step();
        load = 1'b0;
        steps(3);
        en = 1'b0;
        steps(5);
        en = 1'b1;
        steps(6);
        check("stretch before tick", 16'(value), 16'h0000);
        step();
        check("stretch tick at 15", 16'(value), 16'h0001);
        steps(DIV - 1);
        check("stretch next period", 16'(value), 16'h0001);
        load     = 1'b1;
        load_val = 8'h5A;
        step();
        load = 1'b0;
        check("load beats tick", 16'(value), 16'h005A);
        check("load no wrap", 16'(wrap), 16'h0000);
        steps(DIV - 1);
        check("post load hold", 16'(value), 16'h005A);
        step();
        check("post load tick", 16'(value), 16'h005B);

        // Asynchronous reset between clock edges.
        load     = 1'b1;
        load_val = 8'h42;
        step();
        load = 1'b0;
        steps(4);
        check("pre reset value", 16'(value), 16'h0042);
        blank_lz = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async reset value", 16'(value), 16'h0000);
        check("async reset wrap", 16'(wrap), 16'h0000);
        check("async reset seg", 16'(seg), 16'(14'b1000000_1000000));
        #3 rst_n = 1'b1;
        blank_lz = 1'b0;
        steps(DIV - 1);
        check("resume before tick", 16'(value), 16'h0000);
        step();
        check("resume tick", 16'(value), 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
